mod_mem_reader: RTL and testbench

Modulation-memory read sequencer on the FPGA side. The CPU bus writes modulation samples into a two-segment modulation BRAM, where the segment is selected by the modulation write-segment register. This block is the consumer at the other end. It walks the active segment at a programmable sample rate, fetches each 8-bit sample over the BRAM read port, and presents it to the intensity pipeline. It also handles segment switches requested by the controller.

---
 rtl/mod_mem_reader.sv | 190 +++++++++++++++++++
 tb/tb_mod_mem_reader.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_mem_reader.sv
// Modulation-memory read sequencer: walks the active BRAM segment at a programmable sample rate.
// Optional MOD_LOOP_BOUNDARY_SWITCH_EN defers segment switches to the end of the segment loop.
module mod_mem_reader #(
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned IDX_WIDTH  = 15,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 UPDATE_SETTINGS,
    input  logic                 REQ_SEGMENT,
`ifdef MOD_LOOP_BOUNDARY_SWITCH_EN
    input  logic                 TRANSITION_AT_LOOP,
`endif
    input  logic [IDX_WIDTH-1:0] CYCLE_0,
    input  logic [IDX_WIDTH-1:0] CYCLE_1,
    input  logic [DIV_WIDTH-1:0] FREQ_DIV_0,
    input  logic [DIV_WIDTH-1:0] FREQ_DIV_1,
    output logic [IDX_WIDTH:0]   MOD_ADDR,
    input  logic [7:0]           MOD_DATA,
    output logic [7:0]           INTENSITY,
    output logic                 DOUT_VALID,
    output logic [IDX_WIDTH-1:0] IDX,
    output logic                 SEGMENT,
    output logic                 SEGMENT_SWITCHED
);

    // Shortest period that still lets one read return before the next is issued.
    localparam logic [DIV_WIDTH-1:0] FdMin  = DIV_WIDTH'(RD_LATENCY + 2);
    localparam logic [DIV_WIDTH-1:0] DivOne = DIV_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0] IdxOne = IDX_WIDTH'(1);

`ifdef MOD_LOOP_BOUNDARY_SWITCH_EN
    typedef enum logic [1:0] {StIdle, StRun, StPending} state_e;
`else
    typedef enum logic [0:0] {StIdle, StRun} state_e;
`endif

    state_e                 state_q, state_d;
    logic                   seg_q, seg_d;
    logic [IDX_WIDTH-1:0]   cyc_q, cyc_d;
    logic [DIV_WIDTH-1:0]   fd_q, fd_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic                   pend_q, pend_d;
    logic                   pend_seg_q, pend_seg_d;
    logic [IDX_WIDTH:0]     addr_q, addr_d;
    logic [IDX_WIDTH-1:0]   idx_out_q, idx_out_d;
    logic                   switched_q, switched_d;
    logic [RD_LATENCY:0]    pipe_q, pipe_d;
    logic [7:0]             intensity_q, intensity_d;
    logic                   valid_q, valid_d;

    logic running, boundary, apply, issue, load, load_seg;

    function automatic logic [DIV_WIDTH-1:0] clamp_fd(input logic [DIV_WIDTH-1:0] fd);
        return (fd < FdMin) ? FdMin : fd;
    endfunction

    assign running  = (state_q != StIdle);
    assign boundary = running && (div_q == fd_q - DivOne);
    assign issue    = running && (div_q == '0);
`ifdef MOD_LOOP_BOUNDARY_SWITCH_EN
    // A deferred request only lands on the boundary that closes the segment loop.
    assign apply = boundary && pend_q && ((state_q != StPending) || (idx_q == cyc_q));
`else
    assign apply = boundary && pend_q;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (UPDATE_SETTINGS) state_d = StRun;
            end
            default: begin
`ifdef MOD_LOOP_BOUNDARY_SWITCH_EN
                if (apply) state_d = StRun;
                if (UPDATE_SETTINGS) state_d = TRANSITION_AT_LOOP ? StPending : StRun;
`endif
            end
        endcase
    end

    always_comb begin
        seg_d       = seg_q;
        cyc_d       = cyc_q;
        fd_d        = fd_q;
        idx_d       = idx_q;
        div_d       = div_q;
        pend_d      = pend_q;
        pend_seg_d  = pend_seg_q;
        addr_d      = addr_q;
        idx_out_d   = idx_out_q;
        switched_d  = 1'b0;
        load        = 1'b0;
        load_seg    = pend_seg_q;
        intensity_d = intensity_q;

        if (!running) begin
            if (UPDATE_SETTINGS) begin
                load     = 1'b1;
                load_seg = REQ_SEGMENT;
            end
        end else begin
            if (issue) begin
                addr_d    = {seg_q, idx_q};
                idx_out_d = idx_q;
            end
            if (boundary) begin
                div_d = '0;
                idx_d = (idx_q == cyc_q) ? '0 : idx_q + IdxOne;
            end else begin
                div_d = div_q + DivOne;
            end
            if (apply) begin
                load     = 1'b1;
                load_seg = pend_seg_q;
                pend_d   = 1'b0;
            end
            // Registered request: one arriving on a boundary cycle waits for the next boundary.
            if (UPDATE_SETTINGS) begin
                pend_d     = 1'b1;
                pend_seg_d = REQ_SEGMENT;
            end
        end

        if (load) begin
            seg_d      = load_seg;
            cyc_d      = load_seg ? CYCLE_1 : CYCLE_0;
            fd_d       = clamp_fd(load_seg ? FREQ_DIV_1 : FREQ_DIV_0);
            idx_d      = '0;
            div_d      = '0;
            switched_d = 1'b1;
        end

        pipe_d[0] = issue;
        for (int i = 1; i <= int'(RD_LATENCY); i++) pipe_d[i] = pipe_q[i-1];
        valid_d = pipe_q[RD_LATENCY];
        if (pipe_q[RD_LATENCY]) intensity_d = MOD_DATA;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            seg_q       <= 1'b0;
            cyc_q       <= '0;
            fd_q        <= '0;
            idx_q       <= '0;
            div_q       <= '0;
            pend_q      <= 1'b0;
            pend_seg_q  <= 1'b0;
            addr_q      <= '0;
            idx_out_q   <= '0;
            switched_q  <= 1'b0;
            pipe_q      <= '0;
            intensity_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            seg_q       <= seg_d;
            cyc_q       <= cyc_d;
            fd_q        <= fd_d;
            idx_q       <= idx_d;
            div_q       <= div_d;
            pend_q      <= pend_d;
            pend_seg_q  <= pend_seg_d;
            addr_q      <= addr_d;
            idx_out_q   <= idx_out_d;
            switched_q  <= switched_d;
            pipe_q      <= pipe_d;
            intensity_q <= intensity_d;
            valid_q     <= valid_d;
        end
    end

    assign MOD_ADDR         = addr_q;
    assign IDX              = idx_out_q;
    assign SEGMENT          = seg_q;
    assign SEGMENT_SWITCHED = switched_q;
    assign INTENSITY        = intensity_q;
    assign DOUT_VALID       = valid_q;

endmodule

// File: tb/tb_mod_mem_reader.sv
// Bench for mod_mem_reader: a BRAM model plus a schedule-based reference model of the sample
// stream (switch cycles, periods, index wrap) compared against a negedge monitor.
`timescale 1ns/1ps
module tb_mod_mem_reader;
    localparam int unsigned RL = 2;
    localparam int unsigned IW = 15;
    localparam int unsigned DW = 16;
    localparam int FD_MIN = RL + 2;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          UPDATE_SETTINGS = 1'b0;
    logic          REQ_SEGMENT = 1'b0;
`ifdef MOD_LOOP_BOUNDARY_SWITCH_EN
    logic          TRANSITION_AT_LOOP = 1'b0;
`endif
    logic [IW-1:0] CYCLE_0 = '0;
    logic [IW-1:0] CYCLE_1 = '0;
    logic [DW-1:0] FREQ_DIV_0 = '0;
    logic [DW-1:0] FREQ_DIV_1 = '0;
    logic [IW:0]   MOD_ADDR;
    logic [7:0]    MOD_DATA = '0;
    logic [7:0]    rd_d1 = '0;
    logic [7:0]    INTENSITY;
    logic          DOUT_VALID;
    logic [IW-1:0] IDX;
    logic          SEGMENT;
    logic          SEGMENT_SWITCHED;

    bit [7:0] mem [0:65535];

    int vectors = 0;
    int miscompares = 0;
    int cyc_cnt = 0;

    int            mon_c[$];
    logic [7:0]    mon_d[$];
    logic [IW:0]   addr_at[int];
    logic [IW-1:0] idx_at[int];
    logic          sw_at[int];
    logic          seg_at[int];
    int            sw_cnt = 0;

    int sch_s[$];
    int sch_seg[$];
    int sch_cyc[$];
    int sch_fd[$];

    mod_mem_reader #(.RD_LATENCY(RL), .IDX_WIDTH(IW), .DIV_WIDTH(DW)) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .UPDATE_SETTINGS  (UPDATE_SETTINGS),
        .REQ_SEGMENT      (REQ_SEGMENT),
`ifdef MOD_LOOP_BOUNDARY_SWITCH_EN
        .TRANSITION_AT_LOOP(TRANSITION_AT_LOOP),
`endif
        .CYCLE_0          (CYCLE_0),
        .CYCLE_1          (CYCLE_1),
        .FREQ_DIV_0       (FREQ_DIV_0),
        .FREQ_DIV_1       (FREQ_DIV_1),
        .MOD_ADDR         (MOD_ADDR),
        .MOD_DATA         (MOD_DATA),
        .INTENSITY        (INTENSITY),
        .DOUT_VALID       (DOUT_VALID),
        .IDX              (IDX),
        .SEGMENT          (SEGMENT),
        .SEGMENT_SWITCHED (SEGMENT_SWITCHED)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    // Two-register BRAM read port: data valid RL cycles after the address changes.
    always @(posedge CLK) begin
        rd_d1    <= mem[MOD_ADDR];
        MOD_DATA <= rd_d1;
    end

    always @(negedge CLK) begin
        addr_at[cyc_cnt] = MOD_ADDR;
        idx_at[cyc_cnt]  = IDX;
        sw_at[cyc_cnt]   = SEGMENT_SWITCHED;
        seg_at[cyc_cnt]  = SEGMENT;
        if (DOUT_VALID) begin
            mon_c.push_back(cyc_cnt);
            mon_d.push_back(INTENSITY);
        end
        if (SEGMENT_SWITCHED) sw_cnt++;
    end

    function automatic int eff_fd(input int fd);
        return (fd < FD_MIN) ? FD_MIN : fd;
    endfunction

    // First cycle of the new segment: a boundary closes each period, requests must be
    // registered before it, and loop-deferred requests also need the last index of the loop.
    function automatic int next_switch(input int s0, input int fd, input int cyc,
                                       input int u_last, input bit at_loop);
        int m;
        m = 1;
        while ((s0 + fd * m < u_last + 2) || (at_loop && ((m - 1) % (cyc + 1) != cyc))) m++;
        return s0 + fd * m;
    endfunction

    task automatic clear_mon();
        mon_c.delete();
        mon_d.delete();
        addr_at.delete();
        idx_at.delete();
        sw_at.delete();
        seg_at.delete();
        sw_cnt = 0;
        sch_s.delete();
        sch_seg.delete();
        sch_cyc.delete();
        sch_fd.delete();
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        UPDATE_SETTINGS = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        clear_mon();
    endtask

    task automatic wait_until(input int c);
        while (cyc_cnt < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Called at posedge+1; u is the cycle in which UPDATE_SETTINGS is high.
    task automatic pulse_update(input bit seg, input bit tal, output int u);
        UPDATE_SETTINGS = 1'b1;
        REQ_SEGMENT = seg;
`ifdef MOD_LOOP_BOUNDARY_SWITCH_EN
        TRANSITION_AT_LOOP = tal;
`else
        if (tal) $display("note: loop-boundary request issued as immediate");
`endif
        u = cyc_cnt;
        @(posedge CLK);
        #1;
        UPDATE_SETTINGS = 1'b0;
    endtask

    task automatic add_sched(input int s, input bit seg);
        sch_s.push_back(s);
        sch_seg.push_back(int'(seg));
        sch_cyc.push_back(seg ? int'(CYCLE_1) : int'(CYCLE_0));
        sch_fd.push_back(eff_fd(seg ? int'(FREQ_DIV_1) : int'(FREQ_DIV_0)));
    endtask

    task automatic start_run(input bit seg, output int s0);
        int u;
        pulse_update(seg, 1'b0, u);
        s0 = u + 1;
        add_sched(s0, seg);
    endtask

    task automatic check_stream(input string name);
        int         exp_c[$];
        logic [7:0] exp_d[$];
        int         end_c, nxt, issue, idx, n;
        logic [IW:0] a;
        end_c = cyc_cnt;
        for (int j = 0; j < sch_s.size(); j++) begin
            vectors++;
            if (sw_at[sch_s[j]] !== 1'b1 || seg_at[sch_s[j]] !== sch_seg[j][0]) begin
                miscompares++;
                $display("FAIL %s switch%0d @%0d: switched=%b seg=%b, expected 1 and %0d",
                         name, j, sch_s[j], sw_at[sch_s[j]], seg_at[sch_s[j]], sch_seg[j]);
            end
            nxt = (j + 1 < sch_s.size()) ? sch_s[j+1] : end_c;
            for (int k = 0; ; k++) begin
                issue = sch_s[j] + k * sch_fd[j];
                if (issue >= nxt || issue + int'(RL) + 2 >= end_c) break;
                idx = k % (sch_cyc[j] + 1);
                a = {sch_seg[j][0], IW'(idx)};
                vectors++;
                if (addr_at[issue+1] !== a || idx_at[issue+1] !== IW'(idx)) begin
                    miscompares++;
                    $display("FAIL %s addr @%0d: MOD_ADDR=%h IDX=%0d, expected %h / %0d",
                             name, issue + 1, addr_at[issue+1], idx_at[issue+1], a, idx);
                end
                exp_c.push_back(issue + int'(RL) + 2);
                exp_d.push_back(mem[a]);
            end
        end
        vectors++;
        if (mon_c.size() != exp_c.size()) begin
            miscompares++;
            $display("FAIL %s sample_count: got %0d, expected %0d", name, mon_c.size(),
                     exp_c.size());
        end
        vectors++;
        if (sw_cnt != sch_s.size()) begin
            miscompares++;
            $display("FAIL %s switch_count: got %0d, expected %0d", name, sw_cnt, sch_s.size());
        end
        n = (mon_c.size() < exp_c.size()) ? mon_c.size() : exp_c.size();
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (mon_c[i] != exp_c[i] || mon_d[i] !== exp_d[i]) begin
                miscompares++;
                $display("FAIL %s sample%0d: cycle %0d data %h, expected cycle %0d data %h",
                         name, i, mon_c[i], mon_d[i], exp_c[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_reset();
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        vectors++;
        if ({INTENSITY, DOUT_VALID, IDX, SEGMENT, MOD_ADDR, SEGMENT_SWITCHED} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: outputs=%h, expected 0",
                     {INTENSITY, DOUT_VALID, IDX, SEGMENT, MOD_ADDR, SEGMENT_SWITCHED});
        end
        do_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            vectors++;
            if ({INTENSITY, DOUT_VALID, IDX, SEGMENT, MOD_ADDR, SEGMENT_SWITCHED} !== '0) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: outputs=%h, expected 0", i,
                         {INTENSITY, DOUT_VALID, IDX, SEGMENT, MOD_ADDR, SEGMENT_SWITCHED});
            end
        end
    endtask

    task automatic test_seg0_run();
        int s0;
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        mem[3] = 8'h44;
        CYCLE_0 = 3;
        FREQ_DIV_0 = 10;
        do_reset();
        start_run(1'b0, s0);
        wait_until(s0 + 40 + int'(RL) + 3);
        check_stream("seg0_run");
    endtask

    task automatic test_clamp();
        int s0;
        for (int t = 0; t < 2; t++) begin
            CYCLE_0 = IW'($urandom_range(1, 5));
            FREQ_DIV_0 = DW'(t);
            do_reset();
            start_run(1'b0, s0);
            wait_until(s0 + FD_MIN * 8 + 1);
            check_stream(t == 0 ? "clamp_fd0" : "clamp_fd1");
        end
    endtask

    task automatic test_switch();
        int s0, u, s1;
        CYCLE_0 = 3;
        FREQ_DIV_0 = 10;
        CYCLE_1 = 1;
        FREQ_DIV_1 = 6;
        do_reset();
        start_run(1'b0, s0);
        wait_until(s0 + 12);
        pulse_update(1'b1, 1'b0, u);
        s1 = next_switch(s0, 10, 3, u, 1'b0);
        add_sched(s1, 1'b1);
        wait_until(s1 + 6 * 3 + int'(RL) + 3);
        check_stream("imm_switch");
    endtask

    task automatic test_random_switch();
        int s0, u, s1, fd0, k, r;
        bit seg0, seg1, twice;
        for (int it = 0; it < 8; it++) begin
            CYCLE_0 = IW'($urandom_range(0, 5));
            CYCLE_1 = IW'($urandom_range(0, 5));
            FREQ_DIV_0 = DW'($urandom_range(0, 9));
            FREQ_DIV_1 = DW'($urandom_range(0, 9));
            seg0 = 1'($urandom_range(0, 1));
            seg1 = 1'($urandom_range(0, 1));
            twice = 1'($urandom_range(0, 1));
            fd0 = eff_fd(seg0 ? int'(FREQ_DIV_1) : int'(FREQ_DIV_0));
            k = $urandom_range(0, 3);
            r = $urandom_range(0, fd0 - 3);
            do_reset();
            start_run(seg0, s0);
            wait_until(s0 + fd0 * k + r);
            if (twice) begin
                pulse_update(~seg1, 1'b0, u);
                UPDATE_SETTINGS = 1'b1;
                REQ_SEGMENT = seg1;
                u = cyc_cnt;
                @(posedge CLK);
                #1;
                UPDATE_SETTINGS = 1'b0;
            end else begin
                pulse_update(seg1, 1'b0, u);
            end
            s1 = next_switch(s0, fd0, seg0 ? int'(CYCLE_1) : int'(CYCLE_0), u, 1'b0);
            add_sched(s1, seg1);
            wait_until(s1 + sch_fd[1] * (sch_cyc[1] + 2) + int'(RL) + 3);
            check_stream("rand_switch");
        end
    endtask

`ifdef MOD_LOOP_BOUNDARY_SWITCH_EN
    task automatic test_loop_switch();
        int s0, u, s1;
        CYCLE_0 = 3;
        FREQ_DIV_0 = 10;
        CYCLE_1 = 2;
        FREQ_DIV_1 = 7;
        do_reset();
        start_run(1'b0, s0);
        wait_until(s0 + 12);
        pulse_update(1'b0, 1'b1, u);
        wait_until(s0 + 22);
        pulse_update(1'b1, 1'b1, u);
        s1 = next_switch(s0, 10, 3, u, 1'b1);
        add_sched(s1, 1'b1);
        wait_until(s1 + 7 * 4 + int'(RL) + 3);
        check_stream("loop_switch");
    endtask
`endif

    task automatic test_reset_mid_read();
        int s0;
        CYCLE_0 = 3;
        FREQ_DIV_0 = 10;
        do_reset();
        start_run(1'b0, s0);
        wait_until(s0 + 12);
        #2;
        RST_N = 1'b0;
        #1;
        vectors++;
        if ({INTENSITY, DOUT_VALID, IDX, SEGMENT, MOD_ADDR, SEGMENT_SWITCHED} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_values: outputs=%h, expected 0",
                     {INTENSITY, DOUT_VALID, IDX, SEGMENT, MOD_ADDR, SEGMENT_SWITCHED});
        end
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        clear_mon();
        repeat (30) @(posedge CLK);
        #1;
        vectors++;
        if (mon_c.size() != 0 || sw_cnt != 0) begin
            miscompares++;
            $display("FAIL mid_reset_quiet: %0d samples %0d switches, expected 0 and 0",
                     mon_c.size(), sw_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'($urandom);
            mem[32768 + i] = 8'($urandom);
        end
        test_reset();
        test_seg0_run();
        test_clamp();
        test_switch();
        test_random_switch();
`ifdef MOD_LOOP_BOUNDARY_SWITCH_EN
        test_loop_switch();
`endif
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
